i2si_tx_serializer: RTL and testbench

I2SI_TX_SERIALIZER -- requirements
Module: i2si_tx_serializer

---
 rtl/i2si_tx_pkg.sv | 16 +
 rtl/i2si_tx_fifo.sv | 67 ++++++
 rtl/i2si_tx_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_i2si_tx_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2si_tx_pkg.sv
// Shared types and default parameters for the I2S-style transmit serializer.
package i2si_tx_pkg;

  // Serializer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 12;  // sample width
  localparam int DEF_SLOT_W = 16;  // SCK periods per slot
  localparam int DEF_DIV    = 2;   // clk cycles per SCK half-period
  localparam int DEF_DEPTH  = 4;   // FIFO entries (power of two)

endpackage

// File: rtl/i2si_tx_fifo.sv
// Sample FIFO feeding the serializer. Count-based full/empty, combinational
// read port (rdata shows the head entry), storage cleared by reset.
module i2si_tx_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Pointer advance with explicit wrap so any DEPTH stays in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/i2si_tx_serializer.sv
// Left-justified two-slot serial transmitter with a small input FIFO.
// Optional feature: define I2SI_TX_UNDERRUN_CNT_EN to add the saturating
// 8-bit underrun_cnt output.
module i2si_tx_serializer
  import i2si_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int DIV    = DEF_DIV,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  output logic              i2si_sck,
  output logic              i2si_ws,
  output logic              i2si_sd,
  output logic              underrun
`ifdef I2SI_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  state_t             state_r;
  state_t             state_nx_s;
  logic [DCW-1:0]     div_cnt_r;
  logic [BCW-1:0]     bit_cnt_r;
  logic [SLOT_W-1:0]  shreg_r;
  logic               sck_r;
  logic               ws_r;
  logic               underrun_r;

  logic [DATA_W-1:0]  fifo_rdata_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [SLOT_W-1:0]  load_word_s;

  logic               half_tick_s;
  logic               fall_s;
  logic               slot_end_s;
  logic               stop_s;
  logic               load_s;
  logic               pop_s;
  logic               ur_s;

  i2si_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign in_ready = !fifo_full_s;

  // Sample is left-aligned in the slot; the tail pads with zeros. An empty
  // FIFO yields an all-zero slot.
  assign load_word_s = fifo_empty_s ? {SLOT_W{1'b0}}
                                    : (SLOT_W'(fifo_rdata_s) << (SLOT_W - DATA_W));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state plus the slot/load events that drive the datapath and FIFO.
  always_comb begin
    state_nx_s  = state_r;
    half_tick_s = 1'b0;
    fall_s      = 1'b0;
    slot_end_s  = 1'b0;
    stop_s      = 1'b0;
    load_s      = 1'b0;
    if (state_r != IDLE) begin
      half_tick_s = (div_cnt_r == DCW'(DIV - 1));
    end else begin
      half_tick_s = 1'b0;
    end
    fall_s     = half_tick_s && sck_r;
    slot_end_s = fall_s && (bit_cnt_r == BCW'(SLOT_W - 1));
    stop_s     = slot_end_s && ws_r && !enable;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nx_s = LOAD;
          load_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        state_nx_s = SHIFT;
      end
      SHIFT: begin
        if (stop_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = SHIFT;
          load_s     = slot_end_s;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    pop_s = load_s && !fifo_empty_s;
    ur_s  = load_s && fifo_empty_s;
  end

  // Bit clock, word select, shift register and underrun pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r  <= {DCW{1'b0}};
      bit_cnt_r  <= {BCW{1'b0}};
      shreg_r    <= {SLOT_W{1'b0}};
      sck_r      <= 1'b0;
      ws_r       <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (state_r == IDLE) begin
        div_cnt_r  <= {DCW{1'b0}};
        bit_cnt_r  <= {BCW{1'b0}};
        sck_r      <= 1'b0;
        ws_r       <= 1'b0;
        underrun_r <= ur_s;
        if (load_s) begin
          shreg_r <= load_word_s;
        end else begin
          shreg_r <= {SLOT_W{1'b0}};
        end
      end else begin
        if (half_tick_s) begin
          div_cnt_r <= {DCW{1'b0}};
          sck_r     <= ~sck_r;
        end else begin
          div_cnt_r <= div_cnt_r + DCW'(1);
        end
        if (stop_s) begin
          // Right slot finished with enable low: park everything at zero.
          div_cnt_r <= {DCW{1'b0}};
          bit_cnt_r <= {BCW{1'b0}};
          shreg_r   <= {SLOT_W{1'b0}};
          sck_r     <= 1'b0;
          ws_r      <= 1'b0;
        end else if (slot_end_s) begin
          // WS flips together with the next word's MSB (left-justified).
          ws_r       <= ~ws_r;
          shreg_r    <= load_word_s;
          bit_cnt_r  <= {BCW{1'b0}};
          underrun_r <= ur_s;
        end else if (fall_s) begin
          shreg_r   <= shreg_r << 1;
          bit_cnt_r <= bit_cnt_r + BCW'(1);
        end else begin
          shreg_r   <= shreg_r;
          bit_cnt_r <= bit_cnt_r;
        end
      end
    end
  end

  assign i2si_sck = sck_r;
  assign i2si_ws  = ws_r;
  assign i2si_sd  = shreg_r[SLOT_W-1];
  assign underrun = underrun_r;

`ifdef I2SI_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_r;

  // Saturating count of slots started without data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt_r <= 8'd0;
    end else if (ur_s && (underrun_cnt_r != 8'hFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 8'd1;
    end else begin
      underrun_cnt_r <= underrun_cnt_r;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

endmodule

// File: tb/tb_i2si_tx_serializer.sv
// Directed self-checking bench for i2si_tx_serializer (DIV=2, SLOT_W=16).
module tb_i2si_tx_serializer;

  logic        clk;
  logic        rst;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic        i2si_sck;
  logic        i2si_ws;
  logic        i2si_sd;
  logic        underrun;
`ifdef I2SI_TX_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks;
  int errors;

  i2si_tx_serializer #(
    .DATA_W (12),
    .SLOT_W (16),
    .DIV    (2),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .i2si_sck     (i2si_sck),
    .i2si_ws      (i2si_ws),
    .i2si_sd      (i2si_sd),
    .underrun     (underrun)
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {28'd0, i2si_sck, i2si_ws, i2si_sd, underrun}, 32'd0);
  endtask

  // Called at the sample just after a frame's first MSB edge (k=0); checks
  // all 128 clks. Drops enable at sample drop_k.
  task automatic run_frame(input logic [15:0] left, input logic [15:0] right,
                           input logic ur_left, input logic ur_right, input int drop_k);
    logic [15:0] word;
    logic [3:0]  exp;
    for (int k = 0; k < 128; k++) begin
      if (k > 0) @(negedge clk);
      word   = (k < 64) ? left : right;
      exp[3] = ((k % 4) >= 2);
      exp[2] = (k >= 64);
      exp[1] = word[15 - ((k % 64) / 4)];
      exp[0] = (k == 0) ? ur_left : ((k == 64) ? ur_right : 1'b0);
      check($sformatf("frame k=%0d sck/ws/sd/ur", k),
            {28'd0, i2si_sck, i2si_ws, i2si_sd, underrun}, {28'd0, exp});
      if (k == drop_k) enable = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    in_data  = 12'h000;
    in_valid = 1'b0;
    enable   = 1'b0;

    // Reset held
    repeat (2) @(negedge clk);
    check_idle("reset_outputs");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    check("reset_cnt", {24'd0, underrun_cnt}, 32'd0);
`endif
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("idle_after_release");
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Data: two samples, one frame, enable dropped mid-left slot
    in_valid = 1'b1;
    in_data  = 12'hA5C;
    @(negedge clk);
    in_data  = 12'h123;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 12'hFFF;
    repeat (3) @(negedge clk);
    check_idle("idle_with_data_no_enable");
    enable = 1'b1;
    @(negedge clk);
    run_frame(16'hA5C0, 16'h1230, 1'b0, 1'b0, 10);
    @(negedge clk);
    check_idle("idle_after_data_frame");

    // Underrun: empty FIFO, one frame
    enable = 1'b1;
    @(negedge clk);
    run_frame(16'h0000, 16'h0000, 1'b1, 1'b1, 100);
    @(negedge clk);
    check_idle("idle_after_underrun_frame");
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    check("cnt_after_one_frame", {24'd0, underrun_cnt}, 32'd2);
`endif

    // FIFO full, fifth word waits for the first pop
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 12'h111 * 12'(i + 1);
      @(negedge clk);
      check($sformatf("in_ready after push %0d", i + 1), {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    in_data = 12'h555;
    repeat (2) @(negedge clk);
    check("full_hold_ready", {31'd0, in_ready}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("ready_after_first_pop", {31'd0, in_ready}, 32'd1);
    fork
      run_frame(16'h1110, 16'h2220, 1'b0, 1'b0, -1);
      begin
        @(negedge clk);
        check("fifth_word_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
      end
    join
    // Enable drop mid-left slot of the second frame
    @(negedge clk);
    run_frame(16'h3330, 16'h4440, 1'b0, 1'b0, 10);
    @(negedge clk);
    check_idle("idle_after_enable_drop");
    repeat (3) @(negedge clk);
    check_idle("idle_stays");
    check("retained_not_full", {31'd0, in_ready}, 32'd1);
    // Retained word goes out; right slot underruns
    enable = 1'b1;
    @(negedge clk);
    run_frame(16'h5550, 16'h0000, 1'b0, 1'b1, 0);
    @(negedge clk);
    check_idle("idle_after_retained_frame");
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    check("cnt_after_three", {24'd0, underrun_cnt}, 32'd3);
    // 150 empty frames -> 300 more underruns, counter pinned at 255
    enable = 1'b1;
    @(negedge clk);
    repeat (19190) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check_idle("idle_after_saturation_run");
    check("cnt_saturated", {24'd0, underrun_cnt}, 32'd255);
`endif

    // Async reset mid-SHIFT
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("full_before_reset", {31'd0, in_ready}, 32'd0);
    enable = 1'b1;
    repeat (67) @(negedge clk);
    check("pre_reset_sck_ws_sd", {29'd0, i2si_sck, i2si_ws, i2si_sd}, 32'd7);
    #2 rst = 1'b0;
    #1;
    check_idle("async_reset_outputs");
    check("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    check("async_reset_cnt", {24'd0, underrun_cnt}, 32'd0);
`endif
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_async_release");
    enable = 1'b1;
    @(negedge clk);
    check("fifo_empty_after_reset", {29'd0, i2si_ws, i2si_sd, underrun}, 32'd1);
`ifdef I2SI_TX_UNDERRUN_CNT_EN
    check("cnt_after_reset_underrun", {24'd0, underrun_cnt}, 32'd1);
`endif
    enable = 1'b0;
    repeat (128) @(negedge clk);
    check_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
